// File: rtl/reg_enable_decoder_pkg.sv
// -----------------------------------------------------------------------------
// reg_enable_decoder_pkg
// Shared constants and types for the register-enable burst decoder.
//   N_REGS    : number of register-enable lines (one-hot output width)
//   CODE_W    : register code width, log2(N_REGS)
//   CNT_W     : burst count width, wide enough to hold 0..N_REGS
//   SAT_LIMIT : largest burst length; larger requests are clamped to it
//   state_e   : controller states S_IDLE / S_RUN / S_FIN
// -----------------------------------------------------------------------------
package reg_enable_decoder_pkg;

  localparam int N_REGS = 32;
  localparam int CODE_W = 5;
  localparam int CNT_W  = 6;

  localparam logic [CNT_W-1:0] SAT_LIMIT = CNT_W'(N_REGS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // Clamp a requested burst length to the number of registers, so a burst
  // never revisits a register code.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] count);
    return (count > SAT_LIMIT) ? SAT_LIMIT : count;
  endfunction

endpackage : reg_enable_decoder_pkg

// File: rtl/reg_enable_decoder_dec_5_32.sv
// -----------------------------------------------------------------------------
// dec_5_32
// Purely combinational 5-to-32 decoder; inverse of the 32-to-5 priority
// encoder. Exactly one output bit is set for every input code.
//   code   in  CODE_W  binary register code
//   onehot out N_REGS  one-hot word with bit[code] set
// -----------------------------------------------------------------------------
module dec_5_32
  import reg_enable_decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [N_REGS-1:0] onehot
);

  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule : dec_5_32

// File: rtl/reg_enable_decoder.sv
// -----------------------------------------------------------------------------
// reg_enable_decoder
// Accepts a starting register code and a count, then emits a burst of one-hot
// register-enable words (code, code+1, ... wrapping 31 -> 0) over a valid/ready
// handshake, one word per accepted beat. A single-cycle done pulse follows the
// final beat, or a zero-count request.
//
// Ports:
//   clock        in   1       system clock, rising edge
//   clear        in   1       asynchronous active-low reset
//   start_valid  in   1       burst request valid
//   start_ready  out  1       block can accept a request (IDLE)
//   start_code   in   CODE_W  first register code of the burst
//   start_count  in   CNT_W   number of enables; >N_REGS saturates
//   en_valid     out  1       en_onehot/en_code hold a valid beat (RUN)
//   en_ready     in   1       consumer accepts the current beat
//   en_onehot    out  N_REGS  one-hot enable, bit[en_code] set
//   en_code      out  CODE_W  binary code of the current beat
//   busy         out  1       burst in progress (RUN)
//   done         out  1       one-cycle completion pulse (FIN)
// -----------------------------------------------------------------------------
module reg_enable_decoder
  import reg_enable_decoder_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [CODE_W-1:0] start_code,
  input  logic [CNT_W-1:0]  start_count,
  output logic              en_valid,
  input  logic              en_ready,
  output logic [N_REGS-1:0] en_onehot,
  output logic [CODE_W-1:0] en_code,
  output logic              busy,
  output logic              done
);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   cur_q, cur_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [N_REGS-1:0]   en_onehot_q, en_onehot_d;
  logic [CODE_W-1:0]   en_code_q, en_code_d;
  logic [N_REGS-1:0]   dec_onehot;
  logic                start_fire;
  logic                beat_fire;

  // Status outputs are pure functions of the state register.
  assign start_ready = (state_q == S_IDLE);
  assign busy        = (state_q == S_RUN);
  assign en_valid    = (state_q == S_RUN);
  assign done        = (state_q == S_FIN);

  assign start_fire  = start_valid && start_ready;
  assign beat_fire   = en_valid && en_ready;

  assign en_onehot   = en_onehot_q;
  assign en_code     = en_code_q;

  // The decoder sees the code that will be current after this edge, so the
  // registered enable word is ready in the first RUN cycle (1-cycle latency)
  // and moves to the next code in the same cycle a beat is accepted.
  dec_5_32 u_dec (
    .code   (cur_d),
    .onehot (dec_onehot)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned; that keeps this block free of inferred latches.
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_fire) begin
          cur_d   = start_code;
          rem_d   = sat_count(start_count);
          state_d = (rem_d == '0) ? S_FIN : S_RUN;
        end
      end

      S_RUN: begin
        if (beat_fire) begin
          // CODE_W-bit add wraps 31 -> 0 without extra logic.
          cur_d = cur_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = S_FIN;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // While stalled in RUN cur_d equals cur_q, so the outputs hold steady.
    // Outside RUN the enable word and code are forced to zero.
    en_onehot_d = (state_d == S_RUN) ? dec_onehot : '0;
    en_code_d   = (state_d == S_RUN) ? cur_d      : '0;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      rem_q       <= '0;
      en_onehot_q <= '0;
      en_code_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      cur_q       <= cur_d;
      rem_q       <= rem_d;
      en_onehot_q <= en_onehot_d;
      en_code_q   <= en_code_d;
    end
  end

endmodule : reg_enable_decoder

// File: tb/tb_reg_enable_decoder.sv
// -----------------------------------------------------------------------------
// tb_reg_enable_decoder
// Directed stimulus for reg_enable_decoder. The driver pushes every expected
// beat and done pulse into a scoreboard queue when it issues a request; an
// independent monitor pops and compares whenever the DUT presents a handshake
// beat or a done pulse.
// -----------------------------------------------------------------------------
module tb_reg_enable_decoder;

  logic        clock;
  logic        clear;
  logic        start_valid;
  logic        start_ready;
  logic [4:0]  start_code;
  logic [5:0]  start_count;
  logic        en_valid;
  logic        en_ready;
  logic [31:0] en_onehot;
  logic [4:0]  en_code;
  logic        busy;
  logic        done;

  typedef struct {
    bit          is_done;
    logic [31:0] onehot;
    logic [4:0]  code;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  reg_enable_decoder dut (
    .clock       (clock),
    .clear       (clear),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_code  (start_code),
    .start_count (start_count),
    .en_valid    (en_valid),
    .en_ready    (en_ready),
    .en_onehot   (en_onehot),
    .en_code     (en_code),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: samples on the falling edge, away from the active edge.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    bit          stall_prev;
    logic [31:0] prev_onehot;
    logic [4:0]  prev_code;
    exp_t        e;
    stall_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!clear) begin
        stall_prev = 1'b0;
        continue;
      end
      if (en_valid) begin
        check("onehot_popcount", 32'($countones(en_onehot)), 32'd1);
        if (stall_prev) begin
          check("stall_hold_onehot", en_onehot, prev_onehot);
          check("stall_hold_code", 32'(en_code), 32'(prev_code));
        end
      end else begin
        check("idle_onehot_zero", en_onehot, 32'h0);
        check("idle_code_zero", 32'(en_code), 32'h0);
      end
      if (en_valid && en_ready) begin
        check("beat_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("beat_kind", 32'(e.is_done), 32'd0);
          check("beat_onehot", en_onehot, e.onehot);
          check("beat_code", 32'(en_code), 32'(e.code));
        end
      end
      stall_prev  = en_valid && !en_ready;
      prev_onehot = en_onehot;
      prev_code   = en_code;
      if (done) begin
        check("done_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("done_kind", 32'(e.is_done), 32'd1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (inputs change 1 time unit after the rising edge).
  // ---------------------------------------------------------------------------
  task automatic push_beat(input int code);
    exp_t e;
    e.is_done = 1'b0;
    e.onehot  = 32'h1 << (code % 32);
    e.code    = 5'(code % 32);
    sb.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.onehot  = 32'h0;
    e.code    = 5'd0;
    sb.push_back(e);
  endtask

  // Issue a request; expect at most 'limit' beats (a done only if all fit).
  task automatic send(input logic [4:0] code, input logic [5:0] count, input int limit);
    int n;
    int sat;
    n = 0;
    while (!start_ready && n < 64) begin
      @(posedge clock); #1;
      n++;
    end
    check("start_ready_before_send", 32'(start_ready), 32'd1);
    sat = (count > 6'd32) ? 32 : int'(count);
    for (int i = 0; i < sat && i < limit; i++) push_beat(int'(code) + i);
    if (sat <= limit) push_done();
    start_valid = 1'b1;
    start_code  = code;
    start_count = count;
    @(posedge clock); #1;
    start_valid = 1'b0;
    start_code  = ~code;   // junk: must not be resampled
    start_count = 6'd63;
  endtask

  // Wait until every expected event has been seen, then confirm IDLE.
  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    #1;
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
    check({name, "_ready_after"}, 32'(start_ready), 32'd1);
    check({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : driver
    clear       = 1'b0;
    start_valid = 1'b0;
    start_code  = 5'd0;
    start_count = 6'd0;
    en_ready    = 1'b1;

    // 1. Reset then idle.
    repeat (2) @(posedge clock);
    #1;
    check("rst_en_valid", 32'(en_valid), 32'd0);
    check("rst_en_onehot", en_onehot, 32'h0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    clear = 1'b1;
    @(posedge clock); #1;
    check("idle_start_ready", 32'(start_ready), 32'd1);
    check("idle_en_valid", 32'(en_valid), 32'd0);
    check("idle_en_onehot", en_onehot, 32'h0);
    check("idle_done", 32'(done), 32'd0);

    // 2. Basic burst: codes 3..6.
    send(5'd3, 6'd4, 32);
    check("basic_first_beat_latency", 32'(en_valid), 32'd1);
    wait_drain("basic");

    // 3. Wrap with backpressure: en_ready 1,0,0,1,1.
    en_ready = 1'b1;
    send(5'd30, 6'd3, 32);
    @(posedge clock); #1; en_ready = 1'b0;
    @(posedge clock); #1; en_ready = 1'b0;
    @(posedge clock); #1; en_ready = 1'b1;
    @(posedge clock); #1; en_ready = 1'b1;
    wait_drain("wrap");

    // 4a. Zero count: no beat, done only.
    send(5'd7, 6'd0, 32);
    check("zero_no_valid", 32'(en_valid), 32'd0);
    check("zero_done_now", 32'(done), 32'd1);
    wait_drain("zero");

    // 4b. Saturated count: 40 -> 32 beats, 0..31.
    send(5'd0, 6'd40, 32);
    wait_drain("sat");

    // 5. Clear after the 4th beat of a 10-beat burst.
    send(5'd0, 6'd10, 4);
    repeat (4) @(posedge clock);
    #1;
    clear = 1'b0;
    #1;
    check("midrst_en_valid", 32'(en_valid), 32'd0);
    check("midrst_en_onehot", en_onehot, 32'h0);
    check("midrst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("midrst_no_late_done", 32'(sb.size()), 32'd0);
    send(5'd5, 6'd1, 32);
    wait_drain("midrst_after");

    // 6. Request held during RUN is ignored until the IDLE cycle after done.
    send(5'd3, 6'd4, 32);
    push_beat(20);
    push_beat(21);
    push_done();
    start_valid = 1'b1;
    start_code  = 5'd20;
    start_count = 6'd2;
    begin : hold_req
      int n;
      n = 0;
      while (n < 20) begin
        @(negedge clock);
        if (start_ready) begin
          check("ignored_accept_after_done", 32'(sb.size()), 32'd3);
          @(posedge clock); #1;
          start_valid = 1'b0;
          break;
        end
        n++;
      end
      check("ignored_accept_seen", 32'(n < 20), 32'd1);
      start_valid = 1'b0;
    end
    wait_drain("ignored");

    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_reg_enable_decoder
